sum_hex_uart_tx: RTL
====================

# sum_hex_uart_tx

Downstream stage for the nibble adder. It captures each registered 4-bit sum on a strobe and queues it in a small FIFO. Each sum is transmitted as one ASCII hex character ('0'–'9', 'A'–'F') on a UART 8N1 serial line. The block sits between the adder's uo_out[3:0] and a top-level output pin, so sums can be read with a plain serial terminal.

## Interface
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥ 2.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sum_in  input  4  sum from the adder stage.
- sum_valid  input  1  one-cycle strobe; sum_in is valid this cycle.
- tx  output  1  UART serial out; idle high; registered.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).
- overflow  output  1  sticky; set when a strobe is dropped because the FIFO is full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, FIFO pointers=0.
- Ingest:
  - A sum_valid edge with the FIFO not full pushes sum_in.
  - Fullness is evaluated before any same-edge pop. A strobe while full is dropped and sets overflow, even if the FSM pops on that edge.
  - overflow clears only on reset.
- Encoding, applied at pop:
  - n ≤ 9 → 0x30+n.
  - n ≥ 10 → 0x41+(n−10).
  - 8-bit unsigned arithmetic.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the configuration macro).
  - IDLE: tx=1. If FIFO non-empty, pop head, load encoded byte into the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; a 3-bit counter tracks the bit index. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - On the final STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT−1 and reloads at every state or bit transition.
- Simultaneous push and pop when not full: the level is unchanged and both take effect.
- Reset mid-frame: frame aborts immediately (asynchronous), tx returns to 1, and queued entries are discarded.

## Timing
- Push is visible in fifo_level one cycle after the strobe edge.
- Latency from an idle block: strobe sampled at edge N → pop at edge N+1 → tx low from edge N+1. tx falls 1 cycle after the sampling edge.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity). Back-to-back frames have no gap.
- busy rises with the START transition and falls on the edge entering IDLE.
- Sustained throughput: one character per frame. A strobe rate above that eventually overflows the FIFO.

## Configuration
- SUM_HEX_UART_PARITY_EN defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11×CLKS_PER_BIT.
- Not defined: no PARITY state; 8N1 only.

## Structure
- Shared package:
  - ASCII_ZERO = 8'h30 and ASCII_A = 8'h41.
  - FSM state enum typedef.
  - Frame bit-count constants.
- Sub-module sum_fifo: parameterised synchronous FIFO.
  - Ports: push/pop, data in/out, full/empty/level, asynchronous active-high reset.
  - Top level holds the encoder, FSM, bit timer and shift register.

## Test plan
- sum_in=7 strobe, CLKS_PER_BIT=4:
  - tx low 1 cycle later for 4 cycles.
  - Data bits 1,1,1,0,1,1,0,0 (0x37 LSB first), then stop high.
  - busy high exactly 40 cycles.
- sum_in=12 → byte 0x43 ('C'); sum_in=0 → 0x30; sum_in=15 → 0x46.
- Six strobes on consecutive cycles (values 1..6), FIFO_DEPTH=4:
  - Levels 1,1,2,3,4 and the sixth is dropped; overflow=1.
  - Characters '1'–'5' are sent back-to-back with no idle gap.
- Reset asserted mid-DATA: tx=1, busy=0, fifo_level=0, overflow=0 immediately. The next strobe produces a clean full frame.
- SUM_HEX_UART_PARITY_EN defined, sum_in=7: parity bit=1 (0x37 has five ones), and the frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/sum_hex_uart_tx_pkg.sv
// Shared definitions for the sum_hex_uart_tx block: ASCII bases, FSM state
// type, frame sizing and the nibble-to-hex-character encoder.
// Optional feature macro: SUM_HEX_UART_PARITY_EN (adds an even-parity bit).
package sum_hex_uart_tx_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam int         DATA_BITS  = 8;

`ifdef SUM_HEX_UART_PARITY_EN
  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  // start + 8 data + stop
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // 0..9 -> '0'..'9', 10..15 -> 'A'..'F', all in 8-bit unsigned arithmetic.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    if (n <= 4'd9) return ASCII_ZERO + {4'd0, n};
    else           return ASCII_A + ({4'd0, n} - 8'd10);
  endfunction

endpackage

// File: rtl/sum_hex_uart_tx_if.sv
// Bundle of the sum input strobe and the serial/status outputs of
// sum_hex_uart_tx. The master side is whoever produces sums (the adder or a
// bench); the slave side is the transmitter.
//
// Handshake: sum_valid is a single-cycle strobe qualifying sum_in. There is
// no ready/backpressure; a strobe that arrives while the FIFO is full is
// dropped and latches overflow until reset.
interface sum_hex_uart_tx_if
  import sum_hex_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    sum_in;
  logic          sum_valid;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] fifo_level;
  state_t        dbg_state;

  modport master (
    output sum_in, sum_valid,
    input  tx, busy, overflow, fifo_level, dbg_state
  );

  modport slave (
    input  sum_in, sum_valid,
    output tx, busy, overflow, fifo_level, dbg_state
  );

endinterface

// File: rtl/sum_fifo.sv
// Small synchronous FIFO with a combinational head (o_dout shows the oldest
// entry whenever not empty). Push is ignored when full, pop when empty, so
// fullness is judged on the state before the edge.
module sum_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/sum_hex_uart_tx.sv
// Queues 4-bit sums and sends each one as an ASCII hex character on a UART
// line (8N1). Holds the encoder, framing FSM, bit timer and shift register;
// buffering lives in sum_fifo.
// Optional feature macro: SUM_HEX_UART_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module sum_hex_uart_tx
  import sum_hex_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  sum_hex_uart_tx_if.slave bus
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_parity, w_parity_next;
  logic          r_tx, w_tx_next;
  logic          r_overflow;

  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [3:0]    w_head;
  logic [7:0]    w_byte;
  logic [LW-1:0] w_level;
  logic          w_timer_last;

  sum_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.sum_valid),
    .i_pop   (w_pop),
    .i_din   (bus.sum_in),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_timer_last   = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_byte         = hex_to_ascii(w_head);

  assign bus.tx         = r_tx;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = w_level;
  assign bus.dbg_state  = r_state;

  // Framing registers; tx is registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
    end
  end

  // Sticky flag for a strobe dropped because the FIFO was already full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_overflow <= 1'b0;
    else if (bus.sum_valid && w_full)    r_overflow <= 1'b1;
  end

  // Next-state, pop request and next tx level.
  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer + TW'(1);
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_pop         = 1'b0;
    w_tx_next     = 1'b1;

    case (r_state)
      IDLE: begin
        w_timer_next = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_byte;
          w_parity_next = ^w_byte;
          w_state_next  = START;
        end
      end
      START: begin
        if (w_timer_last) begin
          w_timer_next = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_timer_last) begin
          w_timer_next = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef SUM_HEX_UART_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef SUM_HEX_UART_PARITY_EN
      PARITY: begin
        if (w_timer_last) begin
          w_timer_next = '0;
          w_state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (w_timer_last) begin
          w_timer_next = '0;
          // Chain straight into the next frame when something is queued.
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_next  = w_byte;
            w_parity_next = ^w_byte;
            w_state_next  = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_timer_next = '0;
        w_state_next = IDLE;
      end
    endcase

    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
`ifdef SUM_HEX_UART_PARITY_EN
      PARITY:  w_tx_next = w_parity_next;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

endmodule
